gpi_arbiter: RTL and testbench
==============================

Name: gpi_arbiter

Overview:
- Shares one general peripheral interface (GPI) slave port between N requesters, e.g. several AXI-to-GPI bridges or a debug master feeding one CLINT register file.
- Uses round-robin arbitration.
- Each winning access is registered and issued to the slave as a single-cycle gpi_read/gpi_write strobe.
- Read data is captured and returned to the winner with a one-cycle ack pulse.

Parameters:
N_MASTERS, 2, number of requesters (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_req  in  N_MASTERS  per-requester request; held high until its m_ack
m_write  in  N_MASTERS  per-requester access type: 1 = write, 0 = read
m_addr  in  N_MASTERS*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W]
m_wdata  in  N_MASTERS*DATA_W  per-requester write data, sliced the same way
m_ack  out  N_MASTERS  one-hot, one-cycle completion pulse
m_rdata  out  DATA_W  shared read-data return; valid when any m_ack bit is high
gpi_read  out  1  read strobe to slave
gpi_write  out  1  write strobe to slave
gpi_addr  out  ADDR_W  slave address
gpi_wdata  out  DATA_W  slave write data
gpi_rdata  in  DATA_W  slave read data; combinational, valid in the strobe cycle

Behaviour:
- Clocking and reset: all flops on posedge clk; all flops cleared asynchronously when rst_n is low. No other asynchronous reset paths.
- Reset values:
  - state = IDLE, rr_ptr = 0, cur_idx = 0
  - latched addr/wdata/write cleared to 0
  - m_ack = 0, m_rdata = 0
  - gpi_read = gpi_write = 0, gpi_addr = 0, gpi_wdata = 0
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any m_req bit is set, pick a winner by round-robin: search upward from rr_ptr, modulo N_MASTERS.
  - Latch the winner's index, m_write, m_addr and m_wdata slices, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive gpi_read = !write_q or gpi_write = write_q from registers; drive gpi_addr and gpi_wdata from the latched values.
  - Capture gpi_rdata into rdata_q; for writes, capture 0 instead.
  - Go to RESP.
- RESP:
  - m_ack[cur_idx] = 1 and m_rdata = rdata_q for this cycle.
  - Set rr_ptr = (cur_idx + 1) mod N_MASTERS.
  - Arbitrate again among m_req with bit cur_idx masked (the winner's req is still high this cycle), searching upward from the new rr_ptr.
  - If a winner exists, latch it and go directly to ISSUE; otherwise go to IDLE.
- Latency and throughput:
  - Request first seen in IDLE at cycle T: strobe at T+1, ack at T+2.
  - Sustained throughput is one access per 2 cycles.
- Strobe timing: gpi_read and gpi_write are never both high. Each is high only in ISSUE and for exactly one cycle per access.
- Output defaults: outside ISSUE, gpi_addr and gpi_wdata are 0. Outside RESP, m_ack is 0; m_rdata holds its last value.
- Requester rules:
  - A request dropped before it is latched is simply not served.
  - Changes to m_req, m_addr, m_wdata or m_write after latching have no effect on the access in flight.
- Fairness: with every requester continuously requesting, grants rotate 0, 1, ..., N-1, 0, ... Every requester is served within N grants.
- N_MASTERS = 1: round-robin degenerates; the single requester is granted every other cycle.
- Reset mid-access: asserting rst_n low in ISSUE or RESP aborts immediately. The strobe and ack drop asynchronously and the access is not retried.
- Index widths: cur_idx and rr_ptr are clog2(N_MASTERS) bits wide, with a minimum of 1. The wrap from N-1 to 0 must be explicit, because N_MASTERS need not be a power of 2.

Decomposition:
- Package gpi_pkg: state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2) and a constant-function helper for index width.
- Sub-module rr_picker: purely combinational.
  - Inputs: req vector, mask index, mask enable, start pointer.
  - Outputs: valid and winner index.
  - gpi_arbiter instantiates it once and uses it in both IDLE and RESP.

Test Plan:
- Single read: after reset, m_req[0] = 1, m_write[0] = 0, m_addr[0] = 0x0200_BFF8, gpi_rdata = 0x1234_5678 → gpi_read = 1 with gpi_addr = 0x0200_BFF8 one cycle after the request; next cycle m_ack = 2'b01 and m_rdata = 0x1234_5678.
- Single write: m_req[1] = 1, m_write[1] = 1, m_addr[1] = 0x0200_4000, m_wdata[1] = 0xDEAD_BEEF → one gpi_write pulse with those values; next cycle m_ack = 2'b10; gpi_read stays 0 throughout.
- Contention: both requesters held high for 8 accesses starting from reset → grant order 0, 1, 0, 1, ...; one strobe every 2 cycles; every ack one-hot.
- Withdrawal: m_req[1] raised for one cycle while master 0's access is in ISSUE and dropped before RESP → master 1 never strobed or acked; arbiter returns to IDLE.
- Reset mid-access: rst_n pulled low during ISSUE → gpi_read, gpi_write and m_ack go 0 within the same cycle; after release the arbiter idles, and a new request from master 1 is issued one cycle after it is seen with rr_ptr = 0.
- N_MASTERS = 3, all requesting → grants 0, 1, 2, 0, confirming the explicit wrap at a non-power-of-2 count.

Source files
------------

// File: rtl/gpi_pkg.sv
// Shared definitions for the GPI arbiter: FSM state encoding and index-width helper.
package gpi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after start_i,
// wrapping explicitly at N so non-power-of-2 counts work.
module rr_picker
    import gpi_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] mask_idx_i,
    input  logic          mask_en_i,
    input  logic [IW-1:0] start_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] elig;
    logic [N-1:0] rot;
    logic [IW:0]  sum;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req_i[i] && !(mask_en_i && (mask_idx_i == IW'(i)));
        end
        // rot[k] is the requester sitting k places after start_i.
        rot     = N'({elig, elig} >> start_i);
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                sum     = {1'b0, start_i} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx_o = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gpi_arbiter.sv
// Round-robin arbiter sharing one GPI slave port between N_MASTERS requesters;
// each access is a one-cycle strobe followed by a one-cycle ack.
module gpi_arbiter
    import gpi_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS-1:0]        m_write,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]           m_rdata,
    output logic                        gpi_read,
    output logic                        gpi_write,
    output logic [ADDR_W-1:0]           gpi_addr,
    output logic [DATA_W-1:0]           gpi_wdata,
    input  logic [DATA_W-1:0]           gpi_rdata,
    output state_e                      dbg_state
);

    localparam int IW = idx_width(N_MASTERS);

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       cur_idx_q, cur_idx_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [IW-1:0]       next_ptr, pick_start, pick_idx;
    logic                pick_valid, in_resp;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign in_resp    = (state_q == RESP);
    assign next_ptr   = (cur_idx_q == IW'(N_MASTERS - 1)) ? '0 : cur_idx_q + IW'(1);
    // In RESP the current winner's req is still high, so mask it and start after it.
    assign pick_start = in_resp ? next_ptr : rr_ptr_q;

    rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
        .req_i      (m_req),
        .mask_idx_i (cur_idx_q),
        .mask_en_i  (in_resp),
        .start_i    (pick_start),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_write = m_write[i];
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_idx_d = cur_idx_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cur_idx_d = pick_idx;
                    write_d   = sel_write;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rdata_d = write_q ? '0 : gpi_rdata;
                state_d = RESP;
            end
            RESP: begin
                rr_ptr_d = next_ptr;
                if (pick_valid) begin
                    cur_idx_d = pick_idx;
                    write_d   = sel_write;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    state_d   = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_idx_q <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_idx_q <= cur_idx_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs decode straight from state so reset drops strobe and ack immediately.
    always_comb begin
        gpi_read  = (state_q == ISSUE) && !write_q;
        gpi_write = (state_q == ISSUE) && write_q;
        gpi_addr  = (state_q == ISSUE) ? addr_q : '0;
        gpi_wdata = (state_q == ISSUE) ? wdata_q : '0;
        m_ack     = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_ack[i] = in_resp && (cur_idx_q == IW'(i));
        end
        m_rdata   = rdata_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_gpi_arbiter.sv
// Bench for gpi_arbiter: directed scenarios plus random traffic against an
// event-level reference model, and a 3-requester instance for wrap-around.
module tb_gpi_arbiter;
    import gpi_pkg::*;

    localparam int N  = 2;
    localparam int N3 = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req, m_write, m_ack;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, gpi_wdata, gpi_rdata;
    logic [AW-1:0]   gpi_addr;
    logic            gpi_read, gpi_write;
    state_e          dbg_state;

    logic [N3-1:0]    m_req3, m_write3, m_ack3;
    logic [N3*AW-1:0] m_addr3;
    logic [N3*DW-1:0] m_wdata3;
    logic [DW-1:0]    m_rdata3, gpi_wdata3, gpi_rdata3;
    logic [AW-1:0]    gpi_addr3;
    logic             gpi_read3, gpi_write3;
    state_e           dbg_state3;

    gpi_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .gpi_read(gpi_read),
        .gpi_write(gpi_write), .gpi_addr(gpi_addr), .gpi_wdata(gpi_wdata),
        .gpi_rdata(gpi_rdata), .dbg_state(dbg_state)
    );

    gpi_arbiter #(.N_MASTERS(N3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .m_req(m_req3), .m_write(m_write3), .m_addr(m_addr3),
        .m_wdata(m_wdata3), .m_ack(m_ack3), .m_rdata(m_rdata3), .gpi_read(gpi_read3),
        .gpi_write(gpi_write3), .gpi_addr(gpi_addr3), .gpi_wdata(gpi_wdata3),
        .gpi_rdata(gpi_rdata3), .dbg_state(dbg_state3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected strobe / ack for the current cycle.
    int            rr;
    int            s_idx;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    int            a_idx;
    logic [DW-1:0] exp_rd;
    logic [3:0]    grant_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr     = 0;
        s_idx  = -1;
        a_idx  = -1;
        s_wr   = 1'b0;
        s_addr = '0;
        s_wdata = '0;
        exp_rd = '0;
        grant_q.delete();
    endtask

    task automatic clear_inputs();
        m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0; gpi_rdata = '0;
        m_req3 = '0; m_write3 = '0; m_addr3 = '0; m_wdata3 = '0; gpi_rdata3 = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: compare outputs at negedge, then derive the next cycle's
    // expected events from the arbitration rules and the inputs now applied.
    task automatic tick();
        int            n_s, n_a, mask;
        logic          n_wr;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wdata, n_rd;
        @(negedge clk);
        check("gpi_read",  gpi_read,  (s_idx >= 0) && !s_wr);
        check("gpi_write", gpi_write, (s_idx >= 0) && s_wr);
        check("gpi_addr",  gpi_addr,  (s_idx >= 0) ? s_addr : '0);
        check("gpi_wdata", gpi_wdata, (s_idx >= 0) ? s_wdata : '0);
        check("m_ack",     m_ack,     (a_idx >= 0) ? (64'd1 << a_idx) : 64'd0);
        check("m_rdata",   m_rdata,   exp_rd);
        n_s = -1; n_a = -1; n_wr = 1'b0; n_addr = '0; n_wdata = '0; n_rd = '0;
        if (s_idx >= 0) begin
            n_a  = s_idx;
            n_rd = s_wr ? '0 : gpi_rdata;
        end else begin
            mask = -1;
            if (a_idx >= 0) begin
                rr   = (a_idx + 1) % N;
                mask = a_idx;
            end
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (n_s < 0 && m_req[c] && c != mask) n_s = c;
            end
            if (n_s >= 0) begin
                n_wr    = m_write[n_s];
                n_addr  = m_addr[n_s*AW +: AW];
                n_wdata = m_wdata[n_s*DW +: DW];
                grant_q.push_back(4'(n_s));
            end
        end
        @(posedge clk);
        s_idx = n_s; s_wr = n_wr; s_addr = n_addr; s_wdata = n_wdata;
        a_idx = n_a;
        if (n_a >= 0) exp_rd = n_rd;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        #12;
        check("rst_gpi_read",  gpi_read, 1'b0);
        check("rst_gpi_write", gpi_write, 1'b0);
        check("rst_gpi_addr",  gpi_addr, '0);
        check("rst_gpi_wdata", gpi_wdata, '0);
        check("rst_m_ack",     m_ack, '0);
        check("rst_m_rdata",   m_rdata, '0);
        check("rst_state",     dbg_state, IDLE);
        do_reset();

        // Single read from master 0.
        m_req[0] = 1'b1; m_write[0] = 1'b0;
        m_addr[0 +: AW] = 32'h0200_BFF8; gpi_rdata = 32'h1234_5678;
        tick();
        check("read_strobe", gpi_read, 1'b1);
        check("read_addr", gpi_addr, 32'h0200_BFF8);
        tick();
        check("read_ack", m_ack, 2'b01);
        check("read_data", m_rdata, 32'h1234_5678);
        tick();
        m_req = '0;
        tick();

        // Single write from master 1.
        m_req[1] = 1'b1; m_write[1] = 1'b1;
        m_addr[AW +: AW] = 32'h0200_4000; m_wdata[DW +: DW] = 32'hDEAD_BEEF;
        tick();
        check("write_strobe", gpi_write, 1'b1);
        check("write_wdata", gpi_wdata, 32'hDEAD_BEEF);
        tick();
        check("write_ack", m_ack, 2'b10);
        tick();
        m_req = '0;
        tick();

        // Contention from reset: both held high for 8 accesses.
        do_reset();
        m_req = 2'b11; m_write = 2'b01;
        m_addr = {32'h0000_1111, 32'h0000_0000};
        repeat (16) tick();
        check("contend_grants", grant_q.size(), 8);
        for (int i = 0; i < grant_q.size(); i++) begin
            check("contend_order", grant_q[i], 4'(i % 2));
        end
        m_req = '0;
        repeat (2) tick();

        // Withdrawal: master 1 pulses its request during master 0's strobe cycle.
        grant_q.delete();
        m_req = 2'b01; m_write = 2'b00;
        tick();
        m_req = 2'b11;
        tick();
        m_req = 2'b01;
        tick();
        m_req = 2'b00;
        tick();
        check("withdraw_grants", grant_q.size(), 1);
        check("withdraw_state", dbg_state, IDLE);
        tick();

        // Reset during the strobe cycle aborts the access.
        do_reset();
        m_req = 2'b01;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_read", gpi_read, 1'b0);
        check("abort_ack", m_ack, '0);
        check("abort_state", dbg_state, IDLE);
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_req = 2'b10; m_write = 2'b00; gpi_rdata = 32'h0BAD_F00D;
        tick();
        check("post_rst_strobe", gpi_read, 1'b1);
        tick();
        m_req = '0;
        tick();
        check("post_rst_grant", (grant_q.size() == 1) ? grant_q[0] : 4'hF, 4'd1);

        // Random traffic against the model.
        repeat (300) begin
            m_req     = N'($urandom_range(0, (1 << N) - 1));
            m_write   = N'($urandom_range(0, (1 << N) - 1));
            m_addr    = {$urandom, $urandom};
            m_wdata   = {$urandom, $urandom};
            gpi_rdata = $urandom;
            tick();
        end

        // Three requesters, all requesting: acks rotate 0,1,2,0.
        do_reset();
        m_req3 = 3'b111;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check("n3_ack", m_ack3,
                  (c >= 2 && c % 2 == 0) ? (64'd1 << ((c / 2 - 1) % 3)) : 64'd0);
            check("n3_strobe", gpi_read3, (c % 2 == 1));
            @(posedge clk);
            #1;
        end
        m_req3 = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
